// File: rtl/mux4_sel_sequencer.sv
// Round-robin select sequencer for the downstream mux4_1 stage.
// Grants one requesting channel at a time and holds it for HOLD_CYCLES cycles.
module mux4_sel_sequencer #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned CNT_W       = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] req,
    output logic       s1,
    output logic       s0,
    output logic       valid,
    output logic [3:0] grant,
    output logic       ch_done
);

    localparam int unsigned CH_W = 2;
    localparam int unsigned NCH  = 4;

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CH_W-1:0]   last_ch_q, last_ch_d;
    logic [CH_W-1:0]   sel_q, sel_d;
    logic              valid_q, valid_d;
    logic [NCH-1:0]    grant_q, grant_d;
    logic              ch_done_q, ch_done_d;

    logic [CH_W-1:0]   probe_ch;
    logic [CH_W-1:0]   win_ch;
    logic              win_found;
    logic              decide;
    logic              load;

    // Search upward from the channel after the last winner; the last winner is probed last.
    always_comb begin
        win_found = 1'b0;
        win_ch    = last_ch_q;
        probe_ch  = last_ch_q;
        for (int i = 1; i <= int'(NCH); i++) begin
            probe_ch = last_ch_q + CH_W'(i);
            if (!win_found && req[probe_ch]) begin
                win_found = 1'b1;
                win_ch    = probe_ch;
            end
        end
    end

    assign decide = en && win_found;

    // Next-state and registered-output computation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_ch_d = last_ch_q;
        sel_d     = sel_q;
        valid_d   = valid_q;
        grant_d   = grant_q;
        load      = 1'b0;

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                grant_d = '0;
                if (decide) begin
                    load = 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (decide) begin
                    load = 1'b1;
                end else begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                grant_d = '0;
            end
        endcase

        if (load) begin
            state_d   = HOLD;
            sel_d     = win_ch;
            grant_d   = 4'b0001 << win_ch;
            valid_d   = 1'b1;
            last_ch_d = win_ch;
            cnt_d     = CNT_W'(HOLD_CYCLES - 1);
        end

        // Registered equivalent of valid && (counter == 0).
        ch_done_d = valid_d && (cnt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_ch_q <= CH_W'(NCH - 1);
            sel_q     <= '0;
            valid_q   <= 1'b0;
            grant_q   <= '0;
            ch_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_ch_q <= last_ch_d;
            sel_q     <= sel_d;
            valid_q   <= valid_d;
            grant_q   <= grant_d;
            ch_done_q <= ch_done_d;
        end
    end

    assign s1      = sel_q[1];
    assign s0      = sel_q[0];
    assign valid   = valid_q;
    assign grant   = grant_q;
    assign ch_done = ch_done_q;

endmodule

// File: tb/tb_mux4_sel_sequencer.sv
// Directed bench for mux4_sel_sequencer; a second instance covers the single-cycle dwell.
module tb_mux4_sel_sequencer;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] req;

    logic       s1, s0, valid, ch_done;
    logic [3:0] grant;
    logic       h_s1, h_s0, h_valid, h_ch_done;
    logic [3:0] h_grant;

    logic [7:0] obs;
    logic [7:0] h_obs;

    int vectors;
    int miscompares;

    mux4_sel_sequencer #(.HOLD_CYCLES(4), .CNT_W(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .req     (req),
        .s1      (s1),
        .s0      (s0),
        .valid   (valid),
        .grant   (grant),
        .ch_done (ch_done)
    );

    mux4_sel_sequencer #(.HOLD_CYCLES(1), .CNT_W(3)) dut_h1 (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .req     (req),
        .s1      (h_s1),
        .s0      (h_s0),
        .valid   (h_valid),
        .grant   (h_grant),
        .ch_done (h_ch_done)
    );

    assign obs   = {valid, grant, s1, s0, ch_done};
    assign h_obs = {h_valid, h_grant, h_s1, h_s0, h_ch_done};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {valid, grant, s1, s0, ch_done} for a given select and flags.
    function automatic logic [7:0] ev(input logic v, input logic [1:0] sel, input logic d);
        logic [3:0] g;
        g = v ? (4'b0001 << sel) : 4'b0000;
        return {v, g, sel, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        req = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b1;
        req = 4'b0000;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 2) rst = 1'b0;
            vectors++;
            if (obs !== ev(1'b0, 2'd0, 1'b0)) begin
                miscompares++;
                $display("FAIL reset_idle cyc=%0d got=%b exp=%b", k, obs, ev(1'b0, 2'd0, 1'b0));
            end
        end
    endtask

    task automatic test_single();
        logic [7:0] e;
        do_reset();
        en  = 1'b1;
        req = 4'b0100;
        for (int k = 1; k <= 12; k++) begin
            tick();
            e = ev(1'b1, 2'd2, (k % 4) == 0);
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL single cyc=%0d got=%b exp=%b", k, obs, e);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] e;
        logic [1:0] ch;
        do_reset();
        en  = 1'b1;
        req = 4'b1111;
        for (int k = 1; k <= 20; k++) begin
            tick();
            ch = 2'(((k - 1) / 4) % 4);
            e  = ev(1'b1, ch, (k % 4) == 0);
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL round_robin cyc=%0d got=%b exp=%b", k, obs, e);
            end
        end
    endtask

    task automatic test_skip();
        logic [7:0] e;
        logic [1:0] ch;
        do_reset();
        en  = 1'b1;
        req = 4'b1010;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k <= 12) ch = (((k - 1) / 4) % 2 == 0) ? 2'd1 : 2'd3;
            else         ch = 2'd3;
            e = ev(1'b1, ch, (k % 4) == 0);
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL skip cyc=%0d got=%b exp=%b", k, obs, e);
            end
            if (k == 10) req = 4'b1000;
        end
    endtask

    task automatic test_en_drop(input logic [1:0] ch);
        logic [7:0] e;
        do_reset();
        en  = 1'b1;
        req = 4'b0001 << ch;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k <= 4) e = ev(1'b1, ch, k == 4);
            else        e = ev(1'b0, ch, 1'b0);
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL en_drop ch=%0d cyc=%0d got=%b exp=%b", ch, k, obs, e);
            end
            if (k == 1) en = 1'b0;
        end
    endtask

    task automatic test_reset_mid_dwell();
        logic [7:0] e;
        do_reset();
        en  = 1'b1;
        req = 4'b0100;
        tick();
        tick();
        vectors++;
        if (obs !== ev(1'b1, 2'd2, 1'b0)) begin
            miscompares++;
            $display("FAIL rst_mid_pre got=%b exp=%b", obs, ev(1'b1, 2'd2, 1'b0));
        end
        rst = 1'b1;
        req = 4'b0101;
        tick();
        vectors++;
        if (obs !== ev(1'b0, 2'd0, 1'b0)) begin
            miscompares++;
            $display("FAIL rst_mid_clear got=%b exp=%b", obs, ev(1'b0, 2'd0, 1'b0));
        end
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            e = ev(1'b1, (k <= 4) ? 2'd0 : 2'd2, k == 4);
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL rst_mid_regrant cyc=%0d got=%b exp=%b", k, obs, e);
            end
        end
    endtask

    task automatic test_hold1();
        logic [7:0] e;
        do_reset();
        en  = 1'b1;
        req = 4'b1111;
        for (int k = 1; k <= 8; k++) begin
            tick();
            e = ev(1'b1, 2'((k - 1) % 4), 1'b1);
            vectors++;
            if (h_obs !== e) begin
                miscompares++;
                $display("FAIL hold1 cyc=%0d got=%b exp=%b", k, h_obs, e);
            end
        end
        en = 1'b0;
        tick();
        vectors++;
        if (h_obs !== ev(1'b0, 2'd3, 1'b0)) begin
            miscompares++;
            $display("FAIL hold1_stop got=%b exp=%b", h_obs, ev(1'b0, 2'd3, 1'b0));
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        en  = 1'b0;
        req = 4'b0000;
        test_reset();
        test_single();
        test_round_robin();
        test_skip();
        test_en_drop(2'd0);
        test_en_drop(2'd3);
        test_reset_mid_dwell();
        test_hold1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
